// File: rtl/btn_event_reporter_pkg.sv
// Shared definitions for the button link command decoders.
//
// Holds the command byte values that travel on the SPI protocol layer,
// the field layout of a queued button event word, and the state encoding
// of the read-side serving FSM. The write-side decoder and the event
// reporter both import this package so that the command space stays in
// one place.
package btn_event_reporter_pkg;

  // Command bytes on the protocol layer
  localparam logic [7:0] CMD_WRITE_BTN    = 8'hF4;  // host -> FPGA button state
  localparam logic [7:0] CMD_READ_BTN_EVT = 8'hF5;  // host <- FPGA button events

  // Event word layout: {overflow, seq[3:0], btn[10:0]}
  localparam int EVT_W      = 16;
  localparam int OVF_BIT    = 15;
  localparam int SEQ_MSB    = 14;
  localparam int SEQ_LSB    = 11;
  localparam int BTN_MSB    = 10;
  localparam int SEQ_W      = SEQ_MSB - SEQ_LSB + 1;
  localparam int NBTN_FIXED = BTN_MSB + 1;

  // Read-side serving FSM
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_FILL  = 3'd4
  } rd_state_e;

  // Assemble one event word from its fields.
  function automatic logic [EVT_W-1:0] make_event(
    input logic                  ovf,
    input logic [SEQ_W-1:0]      seq,
    input logic [NBTN_FIXED-1:0] btn
  );
    logic [EVT_W-1:0] evt;
    evt                   = '0;
    evt[OVF_BIT]          = ovf;
    evt[SEQ_MSB:SEQ_LSB]  = seq;
    evt[BTN_MSB:0]        = btn;
    return evt;
  endfunction

endpackage

// File: rtl/btn_event_reporter_evt_fifo.sv
// evt_fifo: DEPTH x WIDTH circular buffer for button event words.
//
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous active-high reset (flushes the buffer)
//   push_i       write push_data_i this cycle (ignored when full unless a
//                pop happens in the same cycle)
//   push_data_i  word to enqueue
//   pop_i        drop the head entry this cycle (ignored when empty)
//   head_o       head entry as it will be after this cycle's pop; lets the
//                consumer register the next byte in the same cycle it pops
//   full_o       occupancy == DEPTH
//   empty_o      occupancy == 0
//   count_o      occupancy, 0..DEPTH
//
// DEPTH must be a power of two (>= 2) so the pointers wrap for free.
module evt_fifo
  import btn_event_reporter_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = EVT_W,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

  // A pop frees the slot this cycle, so a push into a full buffer is
  // accepted when it coincides with a pop.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  assign rd_d = do_pop  ? rd_q + AW'(1) : rd_q;
  assign wr_d = do_push ? wr_q + AW'(1) : wr_q;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Post-pop head: the entry the consumer will see next cycle.
  assign head_o = mem_q[rd_d];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/btn_event_reporter.sv
// btn_event_reporter: reports button changes back to the SPI host.
//
// Every cycle the button vector differs from the previous cycle an event
// word {overflow, seq[3:0], btn[10:0]} is queued. When the host sends the
// read command the block serves, on the byte-level MISO handshake, a count
// byte (occupancy snapshot) followed by that many events, high byte first,
// then 0x00 filler for any further bytes.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   btn_state      decoded button vector (NBTN bits, synchronous to clk)
//   pw_wdata       received byte from the protocol layer
//   pw_wcmd        pw_wdata is a command byte
//   pw_wstb        one-cycle strobe, pw_wdata valid
//   pw_end         one-cycle strobe, transaction ended (CS rise)
//   usr_miso_data  next byte for the SPI core to shift out (registered)
//   usr_miso_ack   one-cycle strobe, core latched usr_miso_data
//   irq            event queue non-empty (registered)
//   overflow       sticky drop flag, cleared once carried by an event
//
// NBTN must be 11: the event word layout has exactly 11 button bits.
module btn_event_reporter
  import btn_event_reporter_pkg::*;
#(
  parameter int         DEPTH    = 8,
  parameter int         NBTN     = 11,
  parameter logic [7:0] CMD_READ = CMD_READ_BTN_EVT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] btn_state,
  input  logic [7:0]      pw_wdata,
  input  logic            pw_wcmd,
  input  logic            pw_wstb,
  input  logic            pw_end,
  output logic [7:0]      usr_miso_data,
  input  logic            usr_miso_ack,
  output logic            irq,
  output logic            overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  rd_state_e        state_q, state_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             ovf_q, ovf_d;
  logic [NBTN-1:0]  prev_q;
  logic [7:0]       data_q, data_d;
  logic             irq_q;

  // FIFO interface
  logic             fifo_push, fifo_pop;
  logic [EVT_W-1:0] fifo_head;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [EVT_W-1:0] evt;

  logic cmd_hit;
  logic btn_chg;

  assign cmd_hit = pw_wstb & pw_wcmd & (pw_wdata == CMD_READ);
  assign btn_chg = (btn_state != prev_q);

  // ---------------------------------------------------------------------
  // Capture
  // ---------------------------------------------------------------------
  assign evt = make_event(ovf_q, seq_q, btn_state[NBTN_FIXED-1:0]);

  // A change is accepted when there is room, counting the slot freed by a
  // pop in the same cycle; otherwise it is dropped and flagged.
  assign fifo_push = btn_chg & (~fifo_full | fifo_pop);

  always_comb begin
    seq_d = seq_q;
    ovf_d = ovf_q;
    if (btn_chg) begin
      if (fifo_push) begin
        seq_d = seq_q + SEQ_W'(1);
        ovf_d = 1'b0;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  evt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (fifo_push),
    .push_data_i (evt),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // ---------------------------------------------------------------------
  // Read-side FSM
  // ---------------------------------------------------------------------
  // Priority: transaction end, then a (re)start command, then the byte ack.
  // An event is popped only when its low byte is acked, so a transaction
  // cut after the high byte leaves the event queued for the next read.
  assign fifo_pop = (state_q == ST_LO) & usr_miso_ack & ~pw_end & ~cmd_hit;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (pw_end) begin
      state_d = ST_IDLE;
    end else if (cmd_hit) begin
      state_d = ST_COUNT;
      rem_d   = fifo_count;
    end else if (usr_miso_ack) begin
      unique case (state_q)
        ST_COUNT: state_d = (rem_q != '0) ? ST_HI : ST_FILL;
        ST_HI:    state_d = ST_LO;
        ST_LO: begin
          rem_d   = rem_q - CW'(1);
          state_d = (rem_q > CW'(1)) ? ST_HI : ST_FILL;
        end
        ST_FILL:  state_d = ST_FILL;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // The output byte is derived from the next state so that it is valid one
  // cycle after the strobe. fifo_head already reflects this cycle's pop, so
  // the LO -> HI step picks up the following event directly.
  always_comb begin
    data_d = 8'h00;
    unique case (state_d)
      ST_COUNT: data_d = 8'(rem_d);
      ST_HI:    data_d = fifo_head[15:8];
      ST_LO:    data_d = fifo_head[7:0];
      default:  data_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      seq_q   <= '0;
      ovf_q   <= 1'b0;
      prev_q  <= '0;
      data_q  <= 8'h00;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      seq_q   <= seq_d;
      ovf_q   <= ovf_d;
      prev_q  <= btn_state;
      data_q  <= data_d;
      irq_q   <= ~fifo_empty;
    end
  end

  assign usr_miso_data = data_q;
  assign irq           = irq_q;
  assign overflow      = ovf_q;

endmodule
